// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared glyph table and brightness width for the display scanner
package display_pkg;

    localparam int BRIGHT_W = 4;

    // Active-low segment patterns, bit 7 = dp (off), bits 6:0 = g..a
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational nybble to active-low 7-segment glyph
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] nybble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK[6:0];
        case (nybble)
            4'h0: seg = SEG_0[6:0];
            4'h1: seg = SEG_1[6:0];
            4'h2: seg = SEG_2[6:0];
            4'h3: seg = SEG_3[6:0];
            4'h4: seg = SEG_4[6:0];
            4'h5: seg = SEG_5[6:0];
            4'h6: seg = SEG_6[6:0];
            4'h7: seg = SEG_7[6:0];
            4'h8: seg = SEG_8[6:0];
            4'h9: seg = SEG_9[6:0];
            4'hA: seg = SEG_A[6:0];
            4'hB: seg = SEG_B[6:0];
            4'hC: seg = SEG_C[6:0];
            4'hD: seg = SEG_D[6:0];
            4'hE: seg = SEG_E[6:0];
            4'hF: seg = SEG_F[6:0];
            default: seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - multiplexed 7-segment scanner with PWM brightness and leading-zero blanking
module display_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int PHASE_DIV     = 6250,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   io_sel,
    output logic [7:0]              io_seg,
    output logic                    frame_tick
);

    localparam int PRESC_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PHASE_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      presc;
    logic [3:0]              phase;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] snap_num;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [BRIGHT_W-1:0]     snap_bri;
    logic                    snap_pending;

    logic presc_wrap;
    logic phase_wrap;
    logic frame_wrap;
    logic slot_first;
    logic lit;

    logic [3:0]            cur_nyb;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            cur_glyph;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] sel_next;

    assign presc_wrap = (presc == PRESC_LAST);
    assign phase_wrap = presc_wrap && (phase == 4'hF);
    assign frame_wrap = phase_wrap && (idx == IDX_LAST);

    // The first cycle of every slot stays dark so the previous digit's segments never ghost
    assign slot_first = (presc == '0) && (phase == 4'h0);
    assign lit        = !slot_first && (phase <= snap_bri);

    assign cur_nyb   = snap_num[{idx, 2'b00} +: 4];
    assign cur_dp    = snap_dp[idx];
    assign cur_blank = blank_mask[idx];

    seg_decoder u_seg_decoder (
        .nybble (cur_nyb),
        .seg    (cur_glyph)
    );

    // A digit is blank when it and every digit above it is zero; digit 0 always shows
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero && (snap_num[4*i +: 4] == 4'h0);
            blank_mask[i] = all_zero && BLANK_LEADING;
        end
    end

    always_comb begin
        sel_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_next[i] = !(lit && (idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            phase        <= 4'h0;
            idx          <= '0;
            snap_num     <= '0;
            snap_dp      <= '0;
            snap_bri     <= '0;
            snap_pending <= 1'b1;
            io_sel       <= '1;
            io_seg       <= SEG_BLANK;
            frame_tick   <= 1'b0;
        end else begin
            snap_pending <= 1'b0;
            frame_tick   <= enable && frame_wrap;

            // Inputs are sampled only at frame boundaries so a frame never shows a torn value
            if (snap_pending || (enable && frame_wrap)) begin
                snap_num <= number;
                snap_dp  <= dp;
                snap_bri <= brightness;
            end

            if (enable) begin
                presc <= presc_wrap ? '0 : presc + 1'b1;
                if (presc_wrap) begin
                    phase <= phase + 4'd1;
                    if (phase_wrap) begin
                        idx <= frame_wrap ? '0 : idx + 1'b1;
                    end
                end
                io_sel <= sel_next;
                io_seg <= {~cur_dp, cur_blank ? SEG_BLANK[6:0] : cur_glyph};
            end else begin
                io_sel <= '1;
                io_seg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - table-driven bench for display_mux (4 digits, 2-cycle phase)
module tb_display_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] number = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    display_mux #(
        .NUM_DIGITS    (4),
        .PHASE_DIV     (2),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .number     (number),
        .dp         (dp),
        .brightness (brightness),
        .io_sel     (io_sel),
        .io_seg     (io_seg),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic        rst;
        logic [15:0] num;
        logic [3:0]  dpv;
        logic [3:0]  bri;
        int          at;
        logic [3:0]  sel;
        logic [7:0]  seg;
        logic        chk_seg;
        logic        tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [15:0] num, input logic [3:0] dpv,
                       input logic [3:0] bri, input int at, input logic [3:0] sel,
                       input logic [7:0] seg, input logic chk_seg, input logic tick);
        vec_t v;
        v.rst = rst; v.num = num; v.dpv = dpv; v.bri = bri; v.at = at;
        v.sel = sel; v.seg = seg; v.chk_seg = chk_seg; v.tick = tick;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dark(input string name);
        check({name, " sel"}, 32'(io_sel), 32'hF);
        check({name, " seg"}, 32'(io_seg), 32'hFF);
        check({name, " tick"}, 32'(frame_tick), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_dark("reset async");
        @(negedge clk);
        check_dark("reset held");
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        int wall;
        int tick_wall;

        // group: 1234 full brightness
        add(1, 16'h1234, 4'h0, 4'hF,   1, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'hF,   2, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF,  32, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF,  33, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'hF,  34, 4'hD, 8'hB0, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF,  66, 4'hB, 8'hA4, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF,  98, 4'h7, 8'hF9, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF, 127, 4'h7, 8'hF9, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF, 128, 4'h7, 8'hF9, 1, 1);
        add(0, 16'h1234, 4'h0, 4'hF, 129, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'hF, 130, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'hF, 256, 4'h7, 8'hF9, 1, 1);
        // group: leading-zero blanking with dp on digit 1
        add(1, 16'h0050, 4'h2, 4'hF,   2, 4'hE, 8'hC0, 1, 0);
        add(0, 16'h0050, 4'h2, 4'hF,  34, 4'hD, 8'h12, 1, 0);
        add(0, 16'h0050, 4'h2, 4'hF,  66, 4'hB, 8'hFF, 1, 0);
        add(0, 16'h0050, 4'h2, 4'hF,  98, 4'h7, 8'hFF, 1, 0);
        // group: brightness 3
        add(1, 16'h1234, 4'h0, 4'h3,   2, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h3,   8, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h3,   9, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'h3,  32, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'h3,  34, 4'hD, 8'hB0, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h3,  40, 4'hD, 8'hB0, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h3,  41, 4'hF, 8'h00, 0, 0);
        // group: brightness 0 lights one cycle per slot
        add(1, 16'h1234, 4'h0, 4'h0,   2, 4'hE, 8'h99, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h0,   3, 4'hF, 8'h00, 0, 0);
        add(0, 16'h1234, 4'h0, 4'h0,  34, 4'hD, 8'hB0, 1, 0);
        add(0, 16'h1234, 4'h0, 4'h0,  35, 4'hF, 8'h00, 0, 0);
        // group: hex glyphs, inner zero not blanked, dp on top digit
        add(1, 16'hFC0B, 4'h8, 4'hF,   2, 4'hE, 8'h83, 1, 0);
        add(0, 16'hFC0B, 4'h8, 4'hF,  34, 4'hD, 8'hC0, 1, 0);
        add(0, 16'hFC0B, 4'h8, 4'hF,  66, 4'hB, 8'hC6, 1, 0);
        add(0, 16'hFC0B, 4'h8, 4'hF,  98, 4'h7, 8'h0E, 1, 0);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                number     = vecs[i].num;
                dp         = vecs[i].dpv;
                brightness = vecs[i].bri;
                enable     = 1'b1;
                do_reset();
            end
            run_to(vecs[i].at);
            check($sformatf("v%0d k%0d sel", i, vecs[i].at), 32'(io_sel), 32'(vecs[i].sel));
            check($sformatf("v%0d k%0d tick", i, vecs[i].at), 32'(frame_tick), 32'(vecs[i].tick));
            if (vecs[i].chk_seg)
                check($sformatf("v%0d k%0d seg", i, vecs[i].at), 32'(io_seg), 32'(vecs[i].seg));
        end

        // mid-frame number change waits for the next frame
        number = 16'h1111; dp = 4'h0; brightness = 4'hF;
        do_reset();
        run_to(66);
        number = 16'h2222;
        run_to(67);  check("chg d2 seg", 32'(io_seg), 32'hF9);
        run_to(98);  check("chg d3 seg", 32'(io_seg), 32'hF9);
        run_to(128); check("chg tick", 32'(frame_tick), 32'h1);
        run_to(130); check("chg d0 seg", 32'(io_seg), 32'hA4);
        run_to(162); check("chg d1 seg", 32'(io_seg), 32'hA4);
        run_to(226); check("chg d3 new seg", 32'(io_seg), 32'hA4);

        // enable gap of 50 cycles mid-slot
        number = 16'h1234;
        do_reset();
        run_to(40);
        enable = 1'b0;
        for (int g = 0; g < 50; g++) begin
            @(posedge clk);
            @(negedge clk);
            if (g == 0 || g == 25 || g == 49)
                check_dark($sformatf("gap %0d", g));
        end
        enable = 1'b1;
        wall = 90;
        tick_wall = 0;
        while (wall < 400 && tick_wall == 0) begin
            @(posedge clk);
            wall++;
            @(negedge clk);
            if (wall == 91) begin
                check("resume sel", 32'(io_sel), 32'hD);
                check("resume seg", 32'(io_seg), 32'hB0);
            end
            if (frame_tick) tick_wall = wall;
        end
        check("gap frame period", 32'(tick_wall), 32'd178);
        k = 128;

        // reset pulse just before a frame wrap
        run_to(255);
        check("pre-rst sel", 32'(io_sel), 32'h7);
        do_reset();
        run_to(1);
        check("post-rst k1 sel", 32'(io_sel), 32'hF);
        check("post-rst k1 tick", 32'(frame_tick), 32'h0);
        run_to(2);
        check("post-rst k2 sel", 32'(io_sel), 32'hE);
        check("post-rst k2 seg", 32'(io_seg), 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter PHASE_DIV, default 6250: clk cycles per brightness phase, legal minimum 1.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 enables leading-zero blanking.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: 1 = scanning, 0 = display dark and counters held.
REQ-008 SHALL have port number, input, 4*NUM_DIGITS bits: one nybble per digit, digit 0 in [3:0].
REQ-009 SHALL have port dp, input, NUM_DIGITS bits: per-digit decimal point, 1 = lit.
REQ-010 SHALL have port brightness, input, 4 bits: 0 = dimmest (1/16 duty), 15 = full.
REQ-011 SHALL have port io_sel, output, NUM_DIGITS bits: active-low digit enables.
REQ-012 SHALL have port io_seg, output, 8 bits: active-low segments, [6:0] = g..a, [7] = dp.
REQ-013 SHALL have port frame_tick, output, 1 bit: one-cycle pulse when the digit index wraps to 0.

Function
REQ-014 SHALL count a prescaler 0..PHASE_DIV-1 while enable=1, wrapping to 0.
REQ-015 SHALL advance a 4-bit phase counter 0..15 on each prescaler wrap, wrapping to 0.
REQ-016 SHALL advance the digit index 0..NUM_DIGITS-1 on each phase wrap (15->0), wrapping to 0; one digit slot lasts 16*PHASE_DIV cycles.
REQ-017 SHALL assert frame_tick for exactly one cycle, registered, on the cycle after the index wraps NUM_DIGITS-1 -> 0.
REQ-018 SHALL snapshot number, dp and brightness into internal registers when the index wraps to 0, and at reset release; mid-frame input changes SHALL NOT appear until the next frame.
REQ-019 SHALL decode the snapshot nybble of the current index: 0-9 as decimal glyphs, 10-15 as hex glyphs A b C d E F.
REQ-020 SHALL, when BLANK_LEADING=1, blank every digit above the most-significant nonzero snapshot nybble, with all segments off and dp still honoured; digit 0 SHALL never be blanked, so 0 displays as "0".
REQ-021 SHALL drive io_sel[index] low only while phase <= snapshot brightness; all other io_sel bits SHALL be high.
REQ-022 SHALL drive all io_sel bits high on the first cycle of every digit slot (ghost suppression), regardless of brightness.
REQ-023 SHALL register io_sel and io_seg: both reflect the index, phase and snapshot of the previous cycle, a latency of 1 cycle.
REQ-024 SHALL, with enable=0, hold prescaler, phase and index, drive io_sel all high and io_seg all high, and suppress frame_tick; on re-enable, scanning SHALL resume from the held state.
REQ-025 SHALL, with NUM_DIGITS=1, assert frame_tick on every phase wrap.

Reset
REQ-026 SHALL, while rst_n=0, set prescaler=0, phase=0, index=0, io_sel all 1, io_seg 8'hFF, frame_tick=0 and snapshot registers to 0, asynchronously.
REQ-027 SHALL, if rst_n asserts mid-slot, abort the slot immediately with no partial frame_tick; after release, scanning SHALL start at digit 0, phase 0.

Structure
REQ-028 SHALL place the glyph constants (active-low segment patterns 0-F, SEG_BLANK=8'hFF) and the brightness width in a shared package display_pkg.
REQ-029 SHALL contain one sub-module, seg_decoder: a combinational nybble-to-active-low-7-segment decoder. The scan counters and snapshot logic SHALL remain in display_mux.

Verification (NUM_DIGITS=4, PHASE_DIV=2, BLANK_LEADING=1 unless stated)
REQ-030 SHALL cover: number=16'h1234, brightness=15 -> io_sel cycles 1110,1101,1011,0111, each low for 31 of 32 cycles; io_seg = glyphs 4,3,2,1; frame_tick every 128 cycles.
REQ-031 SHALL cover: number=16'h0050, dp=4'b0010 -> digits 3,2 blank with io_seg=8'hFF; digit 1 shows "5" with [7]=0; digit 0 shows "0".
REQ-032 SHALL cover: brightness=3 -> each digit's io_sel bit low on cycles 1..7 of its 32-cycle slot and high otherwise.
REQ-033 SHALL cover: number changed 16'h1111 -> 16'h2222 during digit 2 -> digits 2,3 still show "1" in that frame; all digits show "2" after frame_tick.
REQ-034 SHALL cover: enable=0 for 50 cycles mid-slot -> io_sel=4'hF and io_seg=8'hFF during the gap, then the same digit and phase resume; frame period extends by 50 cycles.
REQ-035 SHALL cover: rst_n pulsed low for 1 cycle mid-frame -> outputs reset immediately, and the next lit digit is digit 0.
